queue_serial_tx: RTL and testbench
==================================

// Module: queue_serial_tx
// PURPOSE
//  Drain-side consumer for the queue block. Pops one word whenever the queue is non-empty.
//  Transmits each word on a single wire as an async serial frame: start bit, DATA_BITS data
//  bits LSB first, one stop bit.
//  Sits between a queue's dat_o/pop_i/empty_o and an off-chip TX pin.
// PARAMETERS
//  DATA_BITS  8  width of queue word and of frame payload
//  BAUD_DIV   4  clk_i cycles per serial bit time (>=2)
//  CNT_BITS   8  width of internal bit-time counter; must hold BAUD_DIV-1
// PORTS
//  clk_i      in   1          single clock, all state updates on rising edge
//  reset_i    in   1          synchronous, active-high reset
//  dat_i      in   DATA_BITS  head word from queue dat_o
//  empty_i    in   1          queue empty_o
//  pop_o      out  1          to queue pop_i; registered, one-cycle pulse per word
//  txd_o      out  1          serial line; idle/mark = 1
//  busy_o     out  1          1 in any state except IDLE
//  state_to   out  3          test observation: current state encoding
//  bit_to     out  4          test observation: data bits already sent in current frame
// BEHAVIOUR
//  Reset (reset_i=1 at an edge): state=IDLE, pop_o=0, txd_o=1, busy_o=0, bit_to=0,
//    counter=0. Takes priority over every transition.
//  Reset mid-frame: frame is abandoned, line returns to 1 after that edge, no pop issued.
//  States and encodings: IDLE=0, POP=1, LOAD=2, START=3, DATA=4, STOP=5.
//  IDLE: txd_o=1. At an edge with empty_i=0 -> POP; otherwise stay.
//  POP: exactly one cycle, pop_o=1, txd_o=1. Queue advances on the edge ending POP.
//    Next state is always LOAD.
//  LOAD: one cycle, txd_o=1, pop_o=0. dat_i is captured into the shift register on the
//    edge ending LOAD. Counter clears, then -> START.
//  empty_i is ignored in POP and LOAD; it is sampled only in IDLE.
//  START: txd_o=0 for BAUD_DIV cycles, then -> DATA with bit_to=0.
//  DATA: txd_o=shift[0]; each bit is held BAUD_DIV cycles.
//    At each bit end: shift right, bit_to+1.
//    After bit DATA_BITS-1 completes -> STOP.
//  STOP: txd_o=1 for BAUD_DIV cycles, then -> IDLE; bit_to clears.
//  Counter: counts 0..BAUD_DIV-1 within each bit time and wraps to 0 at each bit boundary.
//  Frame timing: line low at the edge ending LOAD; frame = (DATA_BITS+2)*BAUD_DIV cycles.
//    Back-to-back words insert 3 idle-high cycles (IDLE, POP, LOAD) between stop and start.
//  pop_o is never high two consecutive cycles.
//  pop_o is never asserted while empty_i was 1 at the deciding IDLE edge.
//  Exactly one pop per transmitted frame.
// TESTING  (DATA_BITS=8, BAUD_DIV=4)
//  1. Reset with empty_i=1, hold 10 cycles -> txd_o=1, pop_o=0, busy_o=0, state_to=0
//     throughout.
//  2. empty_i=0, dat_i=8'hA5 -> pop_o high exactly 1 cycle.
//     Then txd_o is 0 x4, then bits 1,0,1,0,0,1,0,1 x4 each, then 1 x4.
//     state_to returns to 0 after 40 cycles from start.
//  3. Two words 8'h00 then 8'hFF queued -> two pops, two 40-cycle frames.
//     Exactly 3 high cycles between first stop end and second start bit.
//  4. empty_i rises to 1 during LOAD -> frame still sent with captured word.
//     No second pop afterwards.
//  5. reset_i pulsed while bit_to=3 -> next cycle txd_o=1, state_to=0, bit_to=0, no pop.
//     Resumes cleanly on next non-empty.
//  6. Data 8'h80 -> txd_o low for 7*4+4 cycles (start + bits 0..6), then high for bit 7
//     and stop (8 cycles).

Source files
------------

// File: rtl/queue_serial_tx.sv
// queue_serial_tx: pops words from a queue and sends each one as an async serial frame
// (start bit, DATA_BITS data bits LSB first, one stop bit) on a single idle-high line.
module queue_serial_tx #(
  parameter int DATA_BITS = 8,
  parameter int BAUD_DIV  = 4,
  parameter int CNT_BITS  = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [DATA_BITS-1:0] dat_i,
  input  logic                 empty_i,
  output logic                 pop_o,
  output logic                 txd_o,
  output logic                 busy_o,
  output logic [2:0]           state_to,
  output logic [3:0]           bit_to
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POP   = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(BAUD_DIV - 1);
  localparam logic [3:0]          BIT_LAST = 4'(DATA_BITS - 1);

  state_t               state;
  logic [CNT_BITS-1:0]  cnt;
  logic [DATA_BITS-1:0] shift;
  logic [DATA_BITS-1:0] shift_next;
  logic                 bit_end;

  assign state_to = state;

  // End-of-bit-time flag and the shift register contents after the next shift.
  always_comb begin
    bit_end    = (cnt == CNT_LAST);
    shift_next = shift >> 1;
  end

  // Frame sequencer; txd_o/pop_o/busy_o are registered alongside the state so each
  // output already holds the value belonging to the state being entered.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state  <= IDLE;
      cnt    <= '0;
      shift  <= '0;
      bit_to <= '0;
      pop_o  <= 1'b0;
      txd_o  <= 1'b1;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty_i) begin
            state  <= POP;
            pop_o  <= 1'b1;
            busy_o <= 1'b1;
          end
        end
        POP: begin
          state <= LOAD;
          pop_o <= 1'b0;
        end
        LOAD: begin
          state <= START;
          shift <= dat_i;
          cnt   <= '0;
          txd_o <= 1'b0;
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            cnt    <= '0;
            bit_to <= '0;
            txd_o  <= shift[0];
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt    <= '0;
            shift  <= shift_next;
            bit_to <= bit_to + 4'd1;
            if (bit_to == BIT_LAST) begin
              state <= STOP;
              txd_o <= 1'b1;
            end else begin
              txd_o <= shift_next[0];
            end
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            state  <= IDLE;
            cnt    <= '0;
            bit_to <= '0;
            busy_o <= 1'b0;
          end else begin
            cnt <= cnt + CNT_BITS'(1);
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          bit_to <= '0;
          pop_o  <= 1'b0;
          txd_o  <= 1'b1;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_queue_serial_tx.sv
// Directed bench for queue_serial_tx with DATA_BITS=8, BAUD_DIV=4.
module tb_queue_serial_tx;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] dat_i = '0;
  logic       empty_i = 1'b1;
  logic       pop_o, txd_o, busy_o;
  logic [2:0] state_to;
  logic [3:0] bit_to;

  int vectors = 0;
  int miscompares = 0;

  queue_serial_tx #(.DATA_BITS(8), .BAUD_DIV(4), .CNT_BITS(8)) dut (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .dat_i    (dat_i),
    .empty_i  (empty_i),
    .pop_o    (pop_o),
    .txd_o    (txd_o),
    .busy_o   (busy_o),
    .state_to (state_to),
    .bit_to   (bit_to)
  );

  always #5 clk_i = ~clk_i;

  // Advance one clock and settle past the edge before sampling or driving.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Expected 40-sample line waveform for one frame starting at the first START cycle.
  function automatic logic [39:0] frame_of(input logic [7:0] d);
    logic [39:0] f;
    for (int i = 0; i < 40; i++) begin
      if (i < 4)       f[i] = 1'b0;
      else if (i < 36) f[i] = d[(i - 4) / 4];
      else             f[i] = 1'b1;
    end
    return f;
  endfunction

  // Offer one word from IDLE, then capture POP/LOAD states and the 40 frame cycles,
  // ending one cycle after the stop bit. empty_i rises after POP or during LOAD.
  task automatic send_word(input logic [7:0] d, input bit drop_in_load,
                           output logic [39:0] line, output int pops,
                           output logic [2:0] st_pop, output logic [2:0] st_load,
                           output logic pop_at_pop);
    dat_i = d;
    empty_i = 1'b0;
    pops = 0;
    tick();
    st_pop = state_to;
    pop_at_pop = pop_o;
    pops += int'(pop_o);
    if (!drop_in_load) empty_i = 1'b1;
    tick();
    st_load = state_to;
    pops += int'(pop_o);
    if (drop_in_load) empty_i = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      line[i] = txd_o;
      pops += int'(pop_o);
    end
    tick();
    pops += int'(pop_o);
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    empty_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++;
      if ({txd_o, pop_o, busy_o, state_to, bit_to} !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0}) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: txd=%b pop=%b busy=%b state=%0d bit=%0d, required txd=1 pop=0 busy=0 state=0 bit=0",
                 i, txd_o, pop_o, busy_o, state_to, bit_to);
      end
    end
    reset_i = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if ({txd_o, pop_o, state_to} !== {1'b1, 1'b0, 3'd0}) begin
      miscompares++;
      $display("FAIL idle_empty: txd=%b pop=%b state=%0d, required 1 0 0", txd_o, pop_o, state_to);
    end
  endtask

  task automatic test_single();
    logic [39:0] line;
    int pops;
    logic [2:0] sp, sl;
    logic pp;
    send_word(8'hA5, 1'b0, line, pops, sp, sl, pp);
    vectors++;
    if ({sp, pp} !== {3'd1, 1'b1}) begin
      miscompares++;
      $display("FAIL single_pop_state: state=%0d pop=%b, required 1 1", sp, pp);
    end
    vectors++;
    if (sl !== 3'd2) begin
      miscompares++;
      $display("FAIL single_load_state: state=%0d, required 2", sl);
    end
    vectors++;
    if (pops !== 1) begin
      miscompares++;
      $display("FAIL single_pop_count: %0d, required 1", pops);
    end
    vectors++;
    if (line !== frame_of(8'hA5)) begin
      miscompares++;
      $display("FAIL single_frame_A5: line=%h, required %h", line, frame_of(8'hA5));
    end
    vectors++;
    if ({state_to, txd_o, busy_o, bit_to} !== {3'd0, 1'b1, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL single_return_idle: state=%0d txd=%b busy=%b bit=%0d, required 0 1 0 0",
               state_to, txd_o, busy_o, bit_to);
    end
  endtask

  task automatic test_back_to_back();
    logic [82:0] stream;
    logic [82:0] exp_stream;
    logic [39:0] f0, f1;
    int pops;
    int consec;
    logic prev_pop;
    f0 = frame_of(8'h00);
    f1 = frame_of(8'hFF);
    for (int i = 0; i < 83; i++) begin
      if (i < 40)      exp_stream[i] = f0[i];
      else if (i < 43) exp_stream[i] = 1'b1;
      else             exp_stream[i] = f1[i - 43];
    end
    pops = 0;
    consec = 0;
    dat_i = 8'h00;
    empty_i = 1'b0;
    tick();
    pops += int'(pop_o);
    prev_pop = pop_o;
    tick();
    pops += int'(pop_o);
    prev_pop = pop_o;
    // Queue head becomes the second word once the first frame has been captured.
    for (int i = 0; i < 83; i++) begin
      tick();
      if (i == 0) dat_i = 8'hFF;
      stream[i] = txd_o;
      pops += int'(pop_o);
      if (prev_pop && pop_o) consec++;
      prev_pop = pop_o;
      if (state_to == 3'd2) empty_i = 1'b1;
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      pops += int'(pop_o);
    end
    vectors++;
    if (stream !== exp_stream) begin
      miscompares++;
      $display("FAIL b2b_stream: line=%h, required %h", stream, exp_stream);
    end
    vectors++;
    if (pops !== 2) begin
      miscompares++;
      $display("FAIL b2b_pop_count: %0d, required 2", pops);
    end
    vectors++;
    if (consec !== 0) begin
      miscompares++;
      $display("FAIL b2b_pop_consecutive: %0d, required 0", consec);
    end
    vectors++;
    if (state_to !== 3'd0) begin
      miscompares++;
      $display("FAIL b2b_end_idle: state=%0d, required 0", state_to);
    end
  endtask

  task automatic test_empty_during_load();
    logic [39:0] line;
    int pops;
    logic [2:0] sp, sl;
    logic pp;
    send_word(8'h3C, 1'b1, line, pops, sp, sl, pp);
    for (int i = 0; i < 10; i++) begin
      tick();
      pops += int'(pop_o);
    end
    vectors++;
    if (line !== frame_of(8'h3C)) begin
      miscompares++;
      $display("FAIL load_drop_frame: line=%h, required %h", line, frame_of(8'h3C));
    end
    vectors++;
    if (pops !== 1) begin
      miscompares++;
      $display("FAIL load_drop_pops: %0d, required 1", pops);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [39:0] line;
    int pops;
    int waited;
    logic [2:0] sp, sl;
    logic pp;
    dat_i = 8'h5A;
    empty_i = 1'b0;
    tick();
    empty_i = 1'b1;
    tick();
    waited = 0;
    tick();
    while (!(state_to == 3'd4 && bit_to == 4'd3) && waited < 60) begin
      tick();
      waited++;
    end
    vectors++;
    if (waited >= 60 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_reach_bit3: state=%0d bit=%0d busy=%b, required state 4 bit 3 busy 1",
               state_to, bit_to, busy_o);
    end
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    vectors++;
    if ({txd_o, pop_o, busy_o, state_to, bit_to} !== {1'b1, 1'b0, 1'b0, 3'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL midreset_after: txd=%b pop=%b busy=%b state=%0d bit=%0d, required 1 0 0 0 0",
               txd_o, pop_o, busy_o, state_to, bit_to);
    end
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      pops += int'(pop_o);
    end
    vectors++;
    if (pops !== 0 || txd_o !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_quiet: pops=%0d txd=%b, required 0 1", pops, txd_o);
    end
    send_word(8'hC3, 1'b0, line, pops, sp, sl, pp);
    vectors++;
    if (line !== frame_of(8'hC3) || pops !== 1) begin
      miscompares++;
      $display("FAIL midreset_resume: line=%h pops=%0d, required %h 1", line, pops, frame_of(8'hC3));
    end
  endtask

  task automatic test_msb_only();
    logic [39:0] line;
    int pops;
    int low_run;
    logic [2:0] sp, sl;
    logic pp;
    send_word(8'h80, 1'b0, line, pops, sp, sl, pp);
    low_run = 0;
    while (low_run < 40 && line[low_run] == 1'b0) low_run++;
    vectors++;
    if (low_run !== 32) begin
      miscompares++;
      $display("FAIL msb_low_run: %0d cycles, required 32", low_run);
    end
    vectors++;
    if (line[39:32] !== 8'hFF) begin
      miscompares++;
      $display("FAIL msb_high_tail: %h, required ff", line[39:32]);
    end
    vectors++;
    if (line !== frame_of(8'h80)) begin
      miscompares++;
      $display("FAIL msb_frame: line=%h, required %h", line, frame_of(8'h80));
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_during_load();
    test_reset_mid_frame();
    test_msb_only();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
